// File: rtl/vga_scanout.sv
// VGA 640x480@60 scan-out: timing counters, low-resolution frame-buffer reader and DAC pin drive.
// Sync, blank and colour travel through matched pipelines so every pin shows the same pixel.

module vga_scanout #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int SCALE_SHIFT = 2,
    parameter int RD_LAT      = 2,
    parameter int ADDR_W      = 15
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [2:0]        rd_data,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK,
    output logic              VGA_SYNC,
    output logic [9:0]        VGA_R,
    output logic [9:0]        VGA_G,
    output logic [9:0]        VGA_B,
    output logic              vblank_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);
    localparam int PIPE_L  = RD_LAT + 2;

    localparam logic [HC_W-1:0] H_LAST    = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0] H_VIS_END = HC_W'(H_VISIBLE);
    localparam logic [HC_W-1:0] HS_BEG    = HC_W'(H_VISIBLE + H_FRONT);
    localparam logic [HC_W-1:0] HS_END    = HC_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VC_W-1:0] V_LAST    = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0] V_VIS_END = VC_W'(V_VISIBLE);
    localparam logic [VC_W-1:0] VS_BEG    = VC_W'(V_VISIBLE + V_FRONT);
    localparam logic [VC_W-1:0] VS_END    = VC_W'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [ADDR_W-1:0] LINE_WORDS = ADDR_W'(H_VISIBLE >> SCALE_SHIFT);

    logic [HC_W-1:0]   hcnt_q, hcnt_d;
    logic [VC_W-1:0]   vcnt_q, vcnt_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [PIPE_L-1:0] vis_pipe_q, vis_pipe_d;
    logic [PIPE_L-1:0] hs_pipe_q, hs_pipe_d;
    logic [PIPE_L-1:0] vs_pipe_q, vs_pipe_d;
    logic [PIPE_L-1:0] vbs_pipe_q, vbs_pipe_d;
    logic [9:0]        red_q, red_d;
    logic [9:0]        grn_q, grn_d;
    logic [9:0]        blu_q, blu_d;

    logic              visible_s0;
    logic              hs_s0;
    logic              vs_s0;
    logic              vbs_s0;
    logic [ADDR_W-1:0] row_idx;
    logic [ADDR_W-1:0] col_idx;

    always_comb begin
        hcnt_d = hcnt_q + 1'b1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
        end
    end

    // Stage-0 decode; sync flags are active low, so 1 means "not in sync".
    always_comb begin
        visible_s0 = (hcnt_q < H_VIS_END) && (vcnt_q < V_VIS_END);
        hs_s0      = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
        vs_s0      = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
        vbs_s0     = (hcnt_q == '0) && (vcnt_q == V_VIS_END);
    end

    always_comb begin
        row_idx   = ADDR_W'(vcnt_q >> SCALE_SHIFT);
        col_idx   = ADDR_W'(hcnt_q >> SCALE_SHIFT);
        rd_addr_d = visible_s0 ? (row_idx * LINE_WORDS + col_idx) : '0;
    end

    always_comb begin
        vis_pipe_d = {vis_pipe_q[PIPE_L-2:0], visible_s0};
        hs_pipe_d  = {hs_pipe_q[PIPE_L-2:0], hs_s0};
        vs_pipe_d  = {vs_pipe_q[PIPE_L-2:0], vs_s0};
        vbs_pipe_d = {vbs_pipe_q[PIPE_L-2:0], vbs_s0};
    end

    // rd_data lines up with the visible flag one stage before the pins.
    always_comb begin
        red_d = '0;
        grn_d = '0;
        blu_d = '0;
        if (vis_pipe_q[PIPE_L-2]) begin
            red_d = {10{rd_data[2]}};
            grn_d = {10{rd_data[1]}};
            blu_d = {10{rd_data[0]}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            rd_addr_q  <= '0;
            vis_pipe_q <= '0;
            hs_pipe_q  <= '1;
            vs_pipe_q  <= '1;
            vbs_pipe_q <= '0;
            red_q      <= '0;
            grn_q      <= '0;
            blu_q      <= '0;
        end else begin
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            rd_addr_q  <= rd_addr_d;
            vis_pipe_q <= vis_pipe_d;
            hs_pipe_q  <= hs_pipe_d;
            vs_pipe_q  <= vs_pipe_d;
            vbs_pipe_q <= vbs_pipe_d;
            red_q      <= red_d;
            grn_q      <= grn_d;
            blu_q      <= blu_d;
        end
    end

    assign rd_addr      = rd_addr_q;
    assign VGA_HS       = hs_pipe_q[PIPE_L-1];
    assign VGA_VS       = vs_pipe_q[PIPE_L-1];
    assign VGA_BLANK    = vis_pipe_q[PIPE_L-1];
    assign VGA_SYNC     = 1'b0;
    assign VGA_R        = red_q;
    assign VGA_G        = grn_q;
    assign VGA_B        = blu_q;
    assign vblank_start = vbs_pipe_q[PIPE_L-1];

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout: a reference pixel model queues the expected pins per edge,
// a negedge monitor pops and compares them and also measures sync/blank/vblank timing.

module tb_vga_scanout;

    // Horizontal timing is the real 640-pixel line; the frame is cut to 15 lines so two frames stay short.
    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_VISIBLE = 8;
    localparam int V_FRONT   = 2;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 3;
    localparam int H_TOTAL   = 800;
    localparam int V_TOTAL   = 15;
    localparam int FRAME     = 12000;
    localparam int LAT       = 4;

    typedef struct {
        int          k;
        int          hp;
        int          vp;
        int          ha;
        int          va;
        bit          is_reset;
        bit          held;
        bit          hs;
        bit          vs;
        bit          blank;
        bit          vbs;
        logic [14:0] addr;
        logic [9:0]  r;
        logic [9:0]  g;
        logic [9:0]  b;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [14:0] rd_addr;
    logic [2:0]  rd_data;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank;
    logic        vga_sync;
    logic [9:0]  vga_r;
    logic [9:0]  vga_g;
    logic [9:0]  vga_b;
    logic        vblank_start;

    logic [14:0] mem_d1 = '0;
    logic [2:0]  mem_d2 = '0;
    logic        hold7 = 1'b0;
    bit          hold_mode = 1'b0;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   k = 0;

    int   hs_run = 0;
    int   blank_run = 0;
    int   vs_run = 0;
    int   vs_runs = 0;
    int   vbs_count = 0;
    int   vbs_last_k = -1;
    int   hs_fall_k = 0;
    bit   first_fall_seen = 1'b0;
    bit   hs_prev = 1'b1;
    bit   vs_prev = 1'b1;
    bit   blank_prev = 1'b0;

    vga_scanout #(
        .H_VISIBLE   (H_VISIBLE),
        .H_FRONT     (H_FRONT),
        .H_SYNC      (H_SYNC),
        .H_BACK      (H_BACK),
        .V_VISIBLE   (V_VISIBLE),
        .V_FRONT     (V_FRONT),
        .V_SYNC      (V_SYNC),
        .V_BACK      (V_BACK),
        .SCALE_SHIFT (2),
        .RD_LAT      (2),
        .ADDR_W      (15)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .VGA_HS       (vga_hs),
        .VGA_VS       (vga_vs),
        .VGA_BLANK    (vga_blank),
        .VGA_SYNC     (vga_sync),
        .VGA_R        (vga_r),
        .VGA_G        (vga_g),
        .VGA_B        (vga_b),
        .vblank_start (vblank_start)
    );

    always #20 clk = ~clk;

    // Frame buffer with a two-clock read latency whose word is the low three address bits.
    always @(posedge clk) begin
        mem_d1 <= rd_addr;
        mem_d2 <= mem_d1[2:0];
    end

    assign rd_data = hold7 ? 3'd7 : mem_d2;

    function automatic bit pix_vis(input int p);
        if (p < 0) return 1'b0;
        return ((p % H_TOTAL) < H_VISIBLE) && (((p / H_TOTAL) % V_TOTAL) < V_VISIBLE);
    endfunction

    function automatic int pix_addr(input int p);
        int h;
        int v;
        h = p % H_TOTAL;
        v = (p / H_TOTAL) % V_TOTAL;
        return (v / 4) * (H_VISIBLE / 4) + (h / 4);
    endfunction

    function automatic exp_t build_exp(input int kk, input bit is_rst, input bit held);
        exp_t e;
        int   pa;
        int   p;
        int   h;
        int   v;
        int   d;
        e.k = kk;
        e.is_reset = is_rst;
        e.held = held;
        e.hp = -1;
        e.vp = -1;
        e.ha = -1;
        e.va = -1;
        e.hs = 1'b1;
        e.vs = 1'b1;
        e.blank = 1'b0;
        e.vbs = 1'b0;
        e.addr = '0;
        e.r = '0;
        e.g = '0;
        e.b = '0;
        if (!is_rst) begin
            pa = kk - 1;
            e.ha = pa % H_TOTAL;
            e.va = (pa / H_TOTAL) % V_TOTAL;
            e.addr = pix_vis(pa) ? 15'(pix_addr(pa)) : 15'd0;
            p = kk - LAT;
            if (p >= 0) begin
                h = p % H_TOTAL;
                v = (p / H_TOTAL) % V_TOTAL;
                e.hp = h;
                e.vp = v;
                e.hs = !((h >= H_VISIBLE + H_FRONT) && (h < H_VISIBLE + H_FRONT + H_SYNC));
                e.vs = !((v >= V_VISIBLE + V_FRONT) && (v < V_VISIBLE + V_FRONT + V_SYNC));
                e.blank = pix_vis(p);
                e.vbs = (h == 0) && (v == V_VISIBLE);
                if (e.blank) begin
                    d = pix_addr(p) & 7;
                    e.r = ((d >> 2) & 1) != 0 ? 10'h3FF : 10'h000;
                    e.g = ((d >> 1) & 1) != 0 ? 10'h3FF : 10'h000;
                    e.b = (d & 1) != 0 ? 10'h3FF : 10'h000;
                end
            end
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input int tag, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d: got 0x%0h, want 0x%0h", name, tag, actual, expected);
        end
    endtask

    // One clock of stimulus; rst_val=0 makes this edge a reset edge. The expected pins are queued after the edge.
    task automatic applyStimulus(input bit rst_val);
        int knext;
        @(negedge clk);
        rst = rst_val;
        knext = rst_val ? k + 1 : 0;
        hold7 = hold_mode && !pix_vis(knext - LAT);
        @(posedge clk);
        k = knext;
        sb_q.push_back(build_exp(k, !rst_val, hold7));
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            checkOutput("rd_addr", mon_e.k, longint'(rd_addr), longint'(mon_e.addr));
            checkOutput("hs", mon_e.k, longint'(vga_hs), longint'(mon_e.hs));
            checkOutput("vs", mon_e.k, longint'(vga_vs), longint'(mon_e.vs));
            checkOutput("blank", mon_e.k, longint'(vga_blank), longint'(mon_e.blank));
            checkOutput("sync", mon_e.k, longint'(vga_sync), 0);
            checkOutput("vblank_start", mon_e.k, longint'(vblank_start), longint'(mon_e.vbs));
            checkOutput("red", mon_e.k, longint'(vga_r), longint'(mon_e.r));
            checkOutput("green", mon_e.k, longint'(vga_g), longint'(mon_e.g));
            checkOutput("blue", mon_e.k, longint'(vga_b), longint'(mon_e.b));
            if (mon_e.is_reset) begin
                hs_run = 0;
                blank_run = 0;
                vs_run = 0;
                vbs_last_k = -1;
                first_fall_seen = 1'b0;
                hs_prev = 1'b1;
                vs_prev = 1'b1;
                blank_prev = 1'b0;
            end else begin
                if (hs_prev && !vga_hs) begin
                    if (!first_fall_seen) checkOutput("hs_first_fall", mon_e.k, mon_e.k, 660);
                    else checkOutput("hs_period", mon_e.k, mon_e.k - hs_fall_k, 800);
                    first_fall_seen = 1'b1;
                    hs_fall_k = mon_e.k;
                end
                if (!vga_hs) hs_run++;
                else if (!hs_prev) begin
                    checkOutput("hs_low_len", mon_e.k, hs_run, 96);
                    hs_run = 0;
                end
                if (vga_blank) blank_run++;
                else if (blank_prev) begin
                    checkOutput("blank_len", mon_e.k, blank_run, 640);
                    blank_run = 0;
                end
                if (vs_prev && !vga_vs) begin
                    checkOutput("vs_fall_line", mon_e.k, mon_e.vp, 10);
                    checkOutput("vs_fall_pix", mon_e.k, mon_e.hp, 0);
                end
                if (!vga_vs) vs_run++;
                else if (!vs_prev) begin
                    checkOutput("vs_low_len", mon_e.k, vs_run, 1600);
                    vs_runs++;
                    vs_run = 0;
                end
                if (vblank_start) begin
                    vbs_count++;
                    checkOutput("vbs_pos_h", mon_e.k, mon_e.hp, 0);
                    checkOutput("vbs_pos_v", mon_e.k, mon_e.vp, 8);
                    if (vbs_last_k >= 0) checkOutput("frame_period", mon_e.k, mon_e.k - vbs_last_k, 12000);
                    vbs_last_k = mon_e.k;
                end
                if (mon_e.ha == 4 && mon_e.va == 4) checkOutput("addr_4_4", mon_e.k, longint'(rd_addr), 161);
                if (mon_e.ha == 639 && mon_e.va == 7) checkOutput("addr_639_7", mon_e.k, longint'(rd_addr), 319);
                if (mon_e.ha == 640 && mon_e.va == 0) checkOutput("addr_640_0", mon_e.k, longint'(rd_addr), 0);
                if (mon_e.hp == 4 && mon_e.vp == 0) begin
                    checkOutput("pix4_blue", mon_e.k, longint'(vga_b), 'h3FF);
                    checkOutput("pix4_red", mon_e.k, longint'(vga_r), 0);
                    checkOutput("pix4_green", mon_e.k, longint'(vga_g), 0);
                end
                if (mon_e.held) checkOutput("hold7_rgb", mon_e.k, longint'({vga_r, vga_g, vga_b}), 0);
                hs_prev = vga_hs;
                vs_prev = vga_vs;
                blank_prev = vga_blank;
            end
        end
    end

    initial begin
        $display("[TB] vga_scanout bench start");
        repeat (5) applyStimulus(1'b0);
        for (int i = 0; i < 2 * FRAME + 100; i++) begin
            hold_mode = (i >= FRAME);
            applyStimulus(1'b1);
        end
        hold_mode = 1'b0;
        while (k < 2 * FRAME + 5 * H_TOTAL + 300) applyStimulus(1'b1);
        applyStimulus(1'b0);
        repeat (1000) applyStimulus(1'b1);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("sb_drain", k, sb_q.size(), 0);
        checkOutput("vbs_count", k, vbs_count, 2);
        checkOutput("vs_runs", k, vs_runs, 2);
        checkOutput("hs_fall_after_reset", k, longint'(first_fall_seen), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
